snax_cgra_tcdm_responder: RTL and testbench
===========================================

SNAX_CGRA_TCDM_RESPONDER -- requirements
Module: snax_cgra_tcdm_responder

Interface
REQ-001 The block SHALL have parameter NumPorts, default 4, number of TCDM request ports.
REQ-002 The block SHALL have parameter DataWidth, default 64, data bits per word.
REQ-003 The block SHALL have parameter TCDMAddrWidth, default 48, byte-address width.
REQ-004 The block SHALL have parameter MemDepth, default 64, words of storage, power of two.
REQ-005 The block SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-007 The block SHALL have port tcdm_req_q_valid_i, input, NumPorts, per-port request valid.
REQ-008 The block SHALL have port tcdm_req_write_i, input, NumPorts, 1 = write, 0 = read.
REQ-009 The block SHALL have port tcdm_req_addr_i, input, NumPorts x TCDMAddrWidth, byte address.
REQ-010 The block SHALL have port tcdm_req_data_i, input, NumPorts x DataWidth, write data.
REQ-011 The block SHALL have port tcdm_req_strb_i, input, NumPorts x DataWidth/8, byte write enables.
REQ-012 The block SHALL have port tcdm_rsp_q_ready_o, output, NumPorts, per-port request accept (grant).
REQ-013 The block SHALL have port tcdm_rsp_p_valid_o, output, NumPorts, read-response valid.
REQ-014 The block SHALL have port tcdm_rsp_data_o, output, NumPorts x DataWidth, read data.
REQ-015 The block SHALL have port stall_i, input, 1, forces all q_ready low while high.
REQ-016 The block SHALL have port conflict_cnt_o, output, 16, count of cycles with more than one port requesting.

Function
REQ-017 Word index SHALL be addr[3 +: log2(MemDepth)]; upper address bits SHALL be ignored (wrap modulo MemDepth).
REQ-018 At most one request SHALL be granted per cycle; q_ready SHALL be combinational from q_valid, stall_i and the round-robin pointer.
REQ-019 q_ready[k] SHALL be high only if q_valid[k] high, stall_i low and k is the first requesting port at or after the pointer (circular).
REQ-020 A handshake on port k SHALL occur in a cycle where q_valid[k] and q_ready[k] are both high.
REQ-021 After a handshake on port k, the pointer SHALL become (k+1) mod NumPorts; with no handshake it SHALL hold.
REQ-022 A write handshake SHALL update only the bytes whose strb bit is 1, at the clock edge ending the handshake cycle.
REQ-023 A write SHALL produce no response; p_valid SHALL stay low for writes.
REQ-024 A read handshake in cycle N SHALL drive p_valid[k]=1 and p_data[k]=mem[index] in cycle N+1 only (latency 1, single-cycle pulse, no p_ready).
REQ-025 A read issued in the cycle after a write to the same word SHALL return the written data.
REQ-026 p_data of ports without p_valid SHALL hold its last value.
REQ-027 conflict_cnt_o SHALL increment by 1 in each cycle where more than one q_valid bit is high, regardless of stall_i, and saturate at 0xFFFF.
REQ-028 A port whose q_valid drops before its grant SHALL not be granted; the pointer SHALL be unaffected.

Reset
REQ-029 While rst_ni is low: pointer = 0, all memory words = 0, p_valid = 0, p_data = 0, conflict_cnt_o = 0.
REQ-030 A reset asserted mid-operation SHALL cancel any pending read response; no p_valid SHALL appear after reset release without a new handshake.
REQ-031 q_ready SHALL be 0 while rst_ni is low.

Verification
REQ-032 Port 0 writes 0x1122334455667788 to addr 0x10 with strb 0xFF, then reads 0x10 -> p_valid[0] one cycle after read handshake, data 0x1122334455667788.
REQ-033 Write 0xFFFF_FFFF_FFFF_FFFF to addr 0x18 with strb 0x0F after reset -> read returns 0x00000000FFFFFFFF.
REQ-034 All 4 ports hold read valid continuously from reset -> grants in order 0,1,2,3,0; conflict_cnt_o increases by 1 per cycle.
REQ-035 Read addr 0x200 (index 0 with MemDepth 64) after writing 0xABCD to addr 0x0 -> returns 0xABCD.
REQ-036 stall_i high for 3 cycles with port 2 valid -> q_ready all 0 for 3 cycles, grant to port 2 on the first cycle stall_i is low.
REQ-037 rst_ni pulsed low in the cycle after a read handshake -> p_valid stays 0; subsequent read of any address returns 0.

Source files
------------

// File: rtl/snax_cgra_tcdm_responder.sv
// snax_cgra_tcdm_responder: round-robin multi-port TCDM memory model, one grant per cycle, 1-cycle read latency
module snax_cgra_tcdm_responder #(
  parameter int NumPorts      = 4,
  parameter int DataWidth     = 64,
  parameter int TCDMAddrWidth = 48,
  parameter int MemDepth      = 64
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NumPorts-1:0]                     tcdm_req_q_valid_i,
  input  logic [NumPorts-1:0]                     tcdm_req_write_i,
  input  logic [NumPorts-1:0][TCDMAddrWidth-1:0]  tcdm_req_addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]      tcdm_req_data_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0]    tcdm_req_strb_i,
  output logic [NumPorts-1:0]                     tcdm_rsp_q_ready_o,
  output logic [NumPorts-1:0]                     tcdm_rsp_p_valid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]      tcdm_rsp_data_o,
  input  logic                                    stall_i,
  output logic [15:0]                             conflict_cnt_o
);
  localparam int IdxW  = $clog2(MemDepth);
  localparam int PtrW  = NumPorts > 1 ? $clog2(NumPorts) : 1;
  localparam int StrbW = DataWidth / 8;
  logic [DataWidth-1:0] mem [MemDepth];
  logic [PtrW-1:0] ptr, gnt_idx;
  logic [NumPorts-1:0] gnt;
  logic found, hs, wr_sel, multi, unused_addr;
  logic [IdxW-1:0] idx;
  // first requester at or after the pointer wins, searching circularly
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      if (!found && tcdm_req_q_valid_i[(int'(ptr) + i) % NumPorts]) begin
        gnt[(int'(ptr) + i) % NumPorts] = 1'b1;
        gnt_idx = PtrW'((int'(ptr) + i) % NumPorts);
        found   = 1'b1;
      end
    end
    gnt = (stall_i || !rst_ni) ? '0 : gnt;
  end
  assign tcdm_rsp_q_ready_o = gnt;
  assign hs          = |gnt;
  assign wr_sel      = tcdm_req_write_i[gnt_idx];
  assign idx         = tcdm_req_addr_i[gnt_idx][3 +: IdxW];
  assign multi       = |(tcdm_req_q_valid_i & (tcdm_req_q_valid_i - 1'b1));
  assign unused_addr = ^tcdm_req_addr_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr                <= '0;
      tcdm_rsp_p_valid_o <= '0;
      tcdm_rsp_data_o    <= '0;
      conflict_cnt_o     <= '0;
    end else begin
      if (hs) ptr <= (gnt_idx == PtrW'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
      tcdm_rsp_p_valid_o <= (hs && !wr_sel) ? gnt : '0;
      if (hs && !wr_sel) tcdm_rsp_data_o[gnt_idx] <= mem[idx];
      if (multi && conflict_cnt_o != 16'hFFFF) conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < MemDepth; w++) mem[w] <= '0;
    end else if (hs && wr_sel) begin
      for (int b = 0; b < StrbW; b++)
        if (tcdm_req_strb_i[gnt_idx][b]) mem[idx][8*b +: 8] <= tcdm_req_data_i[gnt_idx][8*b +: 8];
    end
  end
endmodule

// File: tb/tb_snax_cgra_tcdm_responder.sv
// tb_snax_cgra_tcdm_responder: directed vectors with hand-computed expectations
module tb_snax_cgra_tcdm_responder;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic [3:0] valid = '0, write = '0;
  logic [3:0][47:0] addr = '0;
  logic [3:0][63:0] wdata = '0;
  logic [3:0][7:0] strb = '0;
  logic [3:0] ready, pvalid;
  logic [3:0][63:0] rdata;
  logic [15:0] cnt;
  int n_chk = 0, n_err = 0;

  snax_cgra_tcdm_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tcdm_req_q_valid_i(valid), .tcdm_req_write_i(write),
    .tcdm_req_addr_i(addr), .tcdm_req_data_i(wdata), .tcdm_req_strb_i(strb),
    .tcdm_rsp_q_ready_o(ready), .tcdm_rsp_p_valid_o(pvalid), .tcdm_rsp_data_o(rdata),
    .stall_i(stall), .conflict_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [47:0] a, input logic [63:0] d, input logic [7:0] s);
    valid[p] = 1'b1; write[p] = 1'b1; addr[p] = a; wdata[p] = d; strb[p] = s;
    #1;
    check("wr_ready", 64'(ready), 64'd1 << p);
    step;
    check("wr_no_pvalid", 64'(pvalid), 64'd0);
    valid[p] = 1'b0; write[p] = 1'b0;
  endtask

  task automatic rd(input int p, input logic [47:0] a, input logic [63:0] exp);
    valid[p] = 1'b1; write[p] = 1'b0; addr[p] = a;
    #1;
    check("rd_ready", 64'(ready), 64'd1 << p);
    step;
    check("rd_pvalid", 64'(pvalid), 64'd1 << p);
    check("rd_data", rdata[p], exp);
    valid[p] = 1'b0;
    step;
    check("rd_pulse", 64'(pvalid), 64'd0);
  endtask

  initial begin
    valid = 4'hF;
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_pvalid", 64'(pvalid), 64'd0);
    check("rst_data", rdata[0], 64'd0);
    #20;
    check("rst_cnt", 64'(cnt), 64'd0);
    valid = '0;
    step;
    rst_n = 1'b1;
    // all four ports reading continuously: rotate 0,1,2,3,0
    for (int p = 0; p < 4; p++) addr[p] = 48'h10;
    valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_ready", 64'(ready), 64'd1 << (k % 4));
      step;
      check("rr_cnt", 64'(cnt), 64'(k + 1));
      check("rr_pvalid", 64'(pvalid), 64'd1 << (k % 4));
    end
    valid = '0;
    step;
    check("idle_cnt", 64'(cnt), 64'd5);
    check("idle_pvalid", 64'(pvalid), 64'd0);
    stall = 1'b1; valid = 4'b0011;
    #1;
    check("stall_conf_ready", 64'(ready), 64'd0);
    step;
    check("stall_conf_cnt", 64'(cnt), 64'd6);
    check("stall_conf_pvalid", 64'(pvalid), 64'd0);
    valid = '0; stall = 1'b0;
    step;
    wr(0, 48'h10, 64'h1122334455667788, 8'hFF);
    rd(0, 48'h10, 64'h1122334455667788);
    wr(1, 48'h18, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    rd(2, 48'h18, 64'h00000000FFFFFFFF);
    wr(3, 48'h0, 64'hABCD, 8'hFF);
    rd(0, 48'h200, 64'hABCD);
    wr(0, 48'h10, 64'hAAAAAAAAAAAAAAAA, 8'hF0);
    rd(1, 48'h10, 64'hAAAAAAAA55667788);
    stall = 1'b1; valid[2] = 1'b1; write[2] = 1'b0; addr[2] = 48'h10;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 64'(ready), 64'd0);
      step;
      check("stall_pvalid", 64'(pvalid), 64'd0);
    end
    stall = 1'b0;
    #1;
    check("unstall_ready", 64'(ready), 64'd4);
    step;
    check("unstall_pvalid", 64'(pvalid), 64'd4);
    check("unstall_data", rdata[2], 64'hAAAAAAAA55667788);
    valid[2] = 1'b0;
    step;
    // reset right after a read handshake cancels its response
    valid[0] = 1'b1; addr[0] = 48'h10;
    step;
    rst_n = 1'b0; valid[0] = 1'b0;
    #1;
    check("midrst_pvalid", 64'(pvalid), 64'd0);
    check("midrst_data", rdata[0], 64'd0);
    check("midrst_cnt", 64'(cnt), 64'd0);
    step;
    rst_n = 1'b1;
    step;
    check("postrst_pvalid0", 64'(pvalid), 64'd0);
    step;
    check("postrst_pvalid1", 64'(pvalid), 64'd0);
    rd(0, 48'h10, 64'd0);
    rd(1, 48'h18, 64'd0);
    rd(3, 48'h0, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
